dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory (dmem) between the processor's load/store stage and a debug/loader requester.
- The processor has fixed priority. The debug side is served in idle memory slots, with a starvation guard that stalls the processor for one cycle.
- Sits inside skeleton between my_processor and the dmem instance, clocked on the dmem clock domain.

Parameters:
ADDR_W, 12, dmem word-address width
DATA_W, 32, data width
STARVE_LIMIT, 16, consecutive denied debug-request cycles before a forced debug slot (1..255)
READ_LAT, 1, dmem read latency in cycles (1 or 2)

Ports:
clock  in  1  dmem-domain clock
reset  in  1  asynchronous, active-high reset
cpu_en  in  1  processor memory access valid this cycle
cpu_wren  in  1  processor store (1) / load (0)
cpu_addr  in  ADDR_W  processor address
cpu_d  in  DATA_W  processor store data
cpu_q  out  DATA_W  load data to processor (pass-through of q_dmem)
cpu_stall  out  1  processor must hold its access this cycle
dbg_req  in  1  debug request, level, held until dbg_gnt
dbg_wren  in  1  debug write (1) / read (0)
dbg_addr  in  ADDR_W  debug address
dbg_d  in  DATA_W  debug write data
dbg_gnt  out  1  one-cycle pulse: debug access drives memory this cycle
dbg_rvalid  out  1  one-cycle pulse: dbg_q valid
dbg_q  out  DATA_W  registered debug read data
address_dmem  out  ADDR_W  to dmem
data  out  DATA_W  to dmem
wren  out  1  to dmem

Behaviour:
- Reset values: cpu_stall=0, dbg_gnt=0, dbg_rvalid=0, dbg_q=0, wait counter=0, read pipeline cleared, state=IDLE.
- Reset is asynchronous. It aborts any in-flight debug read; no dbg_rvalid is issued for that read.
- Ownership per cycle:
  - Debug owns the port when (dbg_req & !cpu_en) or state==FORCE.
  - Otherwise the processor owns it.
- Memory mux (combinational):
  - Processor owns: address_dmem=cpu_addr, data=cpu_d, wren=cpu_en&cpu_wren.
  - Debug owns: address_dmem=dbg_addr, data=dbg_d, wren=dbg_wren.
  - Idle: wren=0; address and data follow the processor inputs.
- dbg_gnt = 1 exactly in cycles when debug owns the port.
  - The requester samples dbg_gnt at the rising edge and may then present the next request or drop dbg_req.
  - Back-to-back grants are allowed.
- cpu_stall = 1 only in state FORCE. The processor must not advance; its access that cycle is not performed (wren forced to debug value).
- cpu_q = q_dmem unconditionally. The processor never has a read in flight during a debug-owned slot, so no tagging is needed.
- Debug read return:
  - A granted read (dbg_wren=0) enters a READ_LAT-deep valid shift register.
  - At the output, dbg_q <= q_dmem and dbg_rvalid pulses.
  - Latency from dbg_gnt to dbg_rvalid is READ_LAT+1 cycles (registered output).
  - Granted writes produce no rvalid.
- State machine:
  - IDLE: no pending debug request. -> WAIT when dbg_req & cpu_en (denied). Stays in IDLE when dbg_req & !cpu_en (granted immediately).
  - WAIT: counter increments every denied cycle.
    - -> IDLE on grant (idle slot) or when dbg_req drops; counter cleared.
    - -> FORCE when counter reaches STARVE_LIMIT-1 and the cycle is denied.
  - FORCE: exactly one cycle; debug granted, processor stalled. -> IDLE, counter cleared.
- Counter is 8-bit and saturating. It clears on any grant or when dbg_req=0.
- If dbg_req drops in the same cycle FORCE is entered, FORCE is still taken:
  - Treated as a debug read of dbg_addr with no side effect, wren=dbg_wren as sampled.
  - The requester must hold dbg_req until dbg_gnt per protocol; a violation is the requester's fault.
- Simultaneous events:
  - cpu_en=0 with dbg_req=1: debug wins the slot with no stall.
  - cpu_en=1 with dbg_req=0: processor wins the slot; never stalled.

Test Plan:
- Processor only: cpu_en=1, cpu_wren=1, addr 0x010, d 0xDEADBEEF, then read of 0x010 -> wren=1 for one cycle, cpu_q=0xDEADBEEF after READ_LAT, cpu_stall and dbg_gnt never asserted.
- Debug in idle slots: cpu_en=0, dbg write 0x020=0x12345678, then dbg read 0x020 -> dbg_gnt on the first cycle of each request, dbg_rvalid with dbg_q=0x12345678 exactly READ_LAT+1 cycles after the read grant.
- Starvation: cpu_en=1 every cycle, dbg_req=1 read of 0x020 -> cpu_stall=1 and dbg_gnt=1 in the same single cycle, exactly STARVE_LIMIT (16) cycles after dbg_req rose. No processor store to its address is performed in that cycle; the processor store completes the cycle after.
- Request withdrawn: dbg_req high 5 denied cycles then low, then high again under continuous cpu_en -> counter restarts, forced slot at 16 cycles after the second rise, not 11.
- Back-to-back debug reads of 0x000..0x003 with cpu_en=0 -> four consecutive dbg_gnt pulses, four consecutive dbg_rvalid pulses in address order.
- Reset mid-read: assert reset the cycle after a debug read grant -> dbg_rvalid stays 0, all outputs at reset values immediately (asynchronously), state IDLE after release.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Signal bundle linking the processor load/store stage, the debug/loader
// requester and the single-port dmem through the port arbiter.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              cpu_en;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_d;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_wren;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_d;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_q;

  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  // Arbiter side.
  modport slave (
    input  cpu_en, cpu_wren, cpu_addr, cpu_d,
    input  dbg_req, dbg_wren, dbg_addr, dbg_d,
    input  q_dmem,
    output cpu_q, cpu_stall,
    output dbg_gnt, dbg_rvalid, dbg_q,
    output address_dmem, data, wren
  );

  // Requesters and memory side.
  modport master (
    output cpu_en, cpu_wren, cpu_addr, cpu_d,
    output dbg_req, dbg_wren, dbg_addr, dbg_d,
    output q_dmem,
    input  cpu_q, cpu_stall,
    input  dbg_gnt, dbg_rvalid, dbg_q,
    input  address_dmem, data, wren
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port dmem between the processor (fixed priority) and a
// debug/loader port served in idle slots, with a one-cycle forced slot on starvation.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 16,
  parameter int READ_LAT     = 1
) (
  input  logic                clock,
  input  logic                reset,
  dmem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [7:0]          r_cnt;
  logic [READ_LAT-1:0] r_vld;
  logic                r_dbg_rvalid;
  logic [DATA_W-1:0]   r_dbg_q;

  logic                w_denied;
  logic                w_dbg_own;
  logic                w_stall;
  logic [ADDR_W-1:0]   w_addr_mux;

  // A denied cycle: debug is asking but the processor keeps the port.
  assign w_denied = bus.dbg_req & bus.cpu_en & (r_state != S_FORCE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_WAIT: begin
        if (w_denied) w_state_next = (r_cnt >= LIMIT_M1) ? S_FORCE : S_WAIT;
        else          w_state_next = S_IDLE;
      end
      S_FORCE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Ownership is gated by reset so every output sits at its reset value while reset is high.
  always_comb begin
    w_dbg_own = 1'b0;
    w_stall   = 1'b0;
    case (r_state)
      S_FORCE: begin
        w_dbg_own = ~reset;
        w_stall   = ~reset;
      end
      default: w_dbg_own = ~reset & bus.dbg_req & ~bus.cpu_en;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_denied) begin
      if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_addr_mux       = w_dbg_own ? bus.dbg_addr : bus.cpu_addr;
  assign bus.address_dmem = w_addr_mux;
  assign bus.data         = w_dbg_own ? bus.dbg_d : bus.cpu_d;
  assign bus.wren         = w_dbg_own ? bus.dbg_wren : (bus.cpu_en & bus.cpu_wren);

  // Debug read tracking: the valid bit travels alongside the dmem read pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_dbg_own & ~bus.dbg_wren;
      for (int i = 1; i < READ_LAT; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dbg_rvalid <= 1'b0;
      r_dbg_q      <= '0;
    end else begin
      r_dbg_rvalid <= r_vld[READ_LAT-1];
      if (r_vld[READ_LAT-1]) r_dbg_q <= bus.q_dmem;
    end
  end

  assign bus.cpu_q      = bus.q_dmem;
  assign bus.cpu_stall  = w_stall;
  assign bus.dbg_gnt    = w_dbg_own;
  assign bus.dbg_rvalid = r_dbg_rvalid;
  assign bus.dbg_q      = r_dbg_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, directed corner sequences and a
// randomized run checked against a cycle-level behavioural model.
module tb_dmem_port_arbiter;
  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 16;
  localparam int READ_LAT     = 1;
  localparam int DEPTH        = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .READ_LAT(READ_LAT)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  // Single-port dmem with registered read, READ_LAT cycles deep.
  logic [DATA_W-1:0] mem    [0:DEPTH-1];
  logic [DATA_W-1:0] q_pipe [0:READ_LAT-1];
  always @(posedge clk) begin
    if (bus.wren) mem[bus.address_dmem] <= bus.data;
    q_pipe[0] <= mem[bus.address_dmem];
    for (int i = 1; i < READ_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign bus.q_dmem = q_pipe[READ_LAT-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cpu(input logic en, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    bus.cpu_en = en; bus.cpu_wren = wr; bus.cpu_addr = a; bus.cpu_d = d;
  endtask

  task automatic drive_dbg(input logic req, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    bus.dbg_req = req; bus.dbg_wren = wr; bus.dbg_addr = a; bus.dbg_d = d;
  endtask

  typedef struct {
    logic              cpu_en;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_d;
    logic              dbg_req;
    logic              dbg_wren;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_d;
    logic              e_gnt;
    logic              e_stall;
    logic              e_wren;
    logic [ADDR_W-1:0] e_addr;
    logic              e_rvalid;
    logic [DATA_W-1:0] e_q;
    logic              e_qchk;
    logic [DATA_W-1:0] e_cpuq;
  } vec_t;

  vec_t vt [9];

  // Behavioural model state for the randomized phase.
  typedef struct {
    int                due;
    logic [DATA_W-1:0] d;
  } rv_t;
  rv_t               rvq [$];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [DATA_W-1:0] rq      [0:READ_LAT-1];

  initial begin
    #200us;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    int kg;
    int denied;
    int load;
    bit last_gnt;
    bit force_e, gnt_e, wren_e, exp_rv;
    logic [ADDR_W-1:0] addr_e;
    logic [DATA_W-1:0] data_e;

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < READ_LAT; i++) q_pipe[i] = '0;
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_dbg(1'b0, 1'b0, '0, '0);

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall",  64'(bus.cpu_stall),  64'(0));
    chk("reset_gnt",    64'(bus.dbg_gnt),    64'(0));
    chk("reset_rvalid", 64'(bus.dbg_rvalid), 64'(0));
    chk("reset_dbg_q",  64'(bus.dbg_q),      64'(0));
    $display("[TB] reset checked");
    @(negedge clk);
    rst = 1'b0;

    // ---------------- vector table ----------------
    vt[0] = '{1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, 12'h000, 32'h0,
              1'b0, 1'b0, 1'b1, 12'h010, 1'b0, 32'h0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
              1'b0, 1'b0, 1'b0, 12'h010, 1'b0, 32'h0, 1'b0, 32'h0};
    vt[2] = '{1'b0, 1'b0, 12'h055, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
              1'b0, 1'b0, 1'b0, 12'h055, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF};
    vt[3] = '{1'b0, 1'b0, 12'h055, 32'h0, 1'b1, 1'b1, 12'h020, 32'h12345678,
              1'b1, 1'b0, 1'b1, 12'h020, 1'b0, 32'h0, 1'b0, 32'h0};
    vt[4] = '{1'b0, 1'b0, 12'h055, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0,
              1'b1, 1'b0, 1'b0, 12'h020, 1'b0, 32'h0, 1'b0, 32'h0};
    vt[5] = '{1'b1, 1'b1, 12'h030, 32'hCAFEF00D, 1'b1, 1'b1, 12'h040, 32'h0BADF00D,
              1'b0, 1'b0, 1'b1, 12'h030, 1'b0, 32'h0, 1'b0, 32'h0};
    vt[6] = '{1'b0, 1'b0, 12'h030, 32'h0, 1'b1, 1'b1, 12'h040, 32'h0BADF00D,
              1'b1, 1'b0, 1'b1, 12'h040, 1'b1, 32'h12345678, 1'b0, 32'h0};
    vt[7] = '{1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
              1'b0, 1'b0, 1'b0, 12'h010, 1'b0, 32'h0, 1'b0, 32'h0};
    vt[8] = '{1'b0, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
              1'b0, 1'b0, 1'b0, 12'h010, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF};

    for (int v = 0; v < 9; v++) begin
      drive_cpu(vt[v].cpu_en, vt[v].cpu_wren, vt[v].cpu_addr, vt[v].cpu_d);
      drive_dbg(vt[v].dbg_req, vt[v].dbg_wren, vt[v].dbg_addr, vt[v].dbg_d);
      #1;
      chk("vec_gnt",    64'(bus.dbg_gnt),      64'(vt[v].e_gnt));
      chk("vec_stall",  64'(bus.cpu_stall),    64'(vt[v].e_stall));
      chk("vec_wren",   64'(bus.wren),         64'(vt[v].e_wren));
      chk("vec_addr",   64'(bus.address_dmem), 64'(vt[v].e_addr));
      chk("vec_rvalid", 64'(bus.dbg_rvalid),   64'(vt[v].e_rvalid));
      if (vt[v].e_rvalid) chk("vec_dbg_q", 64'(bus.dbg_q), 64'(vt[v].e_q));
      if (vt[v].e_qchk)   chk("vec_cpu_q", 64'(bus.cpu_q), 64'(vt[v].e_cpuq));
      $display("[TB] vec %0d gnt=%0b stall=%0b wren=%0b addr=0x%03h", v,
               bus.dbg_gnt, bus.cpu_stall, bus.wren, bus.address_dmem);
      @(negedge clk);
    end
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_dbg(1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // ---------------- debug read latency in an idle slot ----------------
    drive_dbg(1'b1, 1'b0, 12'h020, '0);
    #1 chk("lat_gnt", 64'(bus.dbg_gnt), 64'(1));
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0);
    #1 chk("lat_rvalid_early", 64'(bus.dbg_rvalid), 64'(0));
    @(negedge clk);
    #1 chk("lat_rvalid", 64'(bus.dbg_rvalid), 64'(1));
    chk("lat_dbg_q", 64'(bus.dbg_q), 64'(32'h12345678));
    @(negedge clk);
    #1 chk("lat_rvalid_pulse", 64'(bus.dbg_rvalid), 64'(0));
    $display("[TB] debug read 0x020 returned 0x%08h", bus.dbg_q);
    @(negedge clk);

    // ---------------- starvation: forced slot ----------------
    kg = -1;
    drive_dbg(1'b1, 1'b0, 12'h020, '0);
    for (int k = 0; k < 40; k++) begin
      drive_cpu(1'b1, 1'b1, 12'h100, 32'hA0000000 + 32'(k));
      #1;
      if (bus.dbg_gnt) begin
        kg = k;
        chk("starve_stall", 64'(bus.cpu_stall),    64'(1));
        chk("starve_wren",  64'(bus.wren),         64'(0));
        chk("starve_addr",  64'(bus.address_dmem), 64'(12'h020));
        break;
      end
      chk("starve_nostall", 64'(bus.cpu_stall), 64'(0));
      @(negedge clk);
    end
    chk("starve_latency", 64'(kg), 64'(STARVE_LIMIT));
    $display("[TB] forced debug slot after %0d cycles", kg);
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0);
    #1;
    chk("starve_cpu_wren",  64'(bus.wren),         64'(1));
    chk("starve_cpu_addr",  64'(bus.address_dmem), 64'(12'h100));
    chk("starve_cpu_stall", 64'(bus.cpu_stall),    64'(0));
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, '0, '0);
    #1;
    chk("starve_rvalid",  64'(bus.dbg_rvalid), 64'(1));
    chk("starve_dbg_q",   64'(bus.dbg_q),      64'(32'h12345678));
    chk("starve_mem_100", 64'(mem[12'h100]),   64'(32'hA0000000 + 32'(kg)));
    @(negedge clk);

    // ---------------- request withdrawn then re-raised ----------------
    drive_cpu(1'b1, 1'b0, 12'h010, '0);
    drive_dbg(1'b1, 1'b0, 12'h020, '0);
    for (int k = 0; k < 5; k++) begin
      #1 chk("wd_denied", 64'(bus.dbg_gnt), 64'(0));
      @(negedge clk);
    end
    drive_dbg(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    kg = -1;
    drive_dbg(1'b1, 1'b0, 12'h020, '0);
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.dbg_gnt) begin kg = k; break; end
      @(negedge clk);
    end
    chk("wd_latency", 64'(kg), 64'(STARVE_LIMIT));
    $display("[TB] re-raised request forced after %0d cycles", kg);
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0);
    drive_cpu(1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);

    // ---------------- back-to-back debug reads ----------------
    for (int i = 0; i < 4; i++) begin
      drive_dbg(1'b1, 1'b1, 12'(i), 32'hB0 + 32'(i));
      #1 chk("b2b_wr_gnt", 64'(bus.dbg_gnt), 64'(1));
      @(negedge clk);
    end
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive_dbg(1'b1, 1'b0, 12'(c), '0);
      else       drive_dbg(1'b0, 1'b0, '0, '0);
      #1;
      chk("b2b_gnt",    64'(bus.dbg_gnt),    64'(c < 4));
      chk("b2b_rvalid", 64'(bus.dbg_rvalid), 64'(c >= 2 && c < 6));
      if (c >= 2 && c < 6) chk("b2b_dbg_q", 64'(bus.dbg_q), 64'(32'hB0 + 32'(c - 2)));
      $display("[TB] b2b cycle %0d gnt=%0b rvalid=%0b dbg_q=0x%08h", c,
               bus.dbg_gnt, bus.dbg_rvalid, bus.dbg_q);
      @(negedge clk);
    end

    // ---------------- reset in the middle of a debug read ----------------
    drive_dbg(1'b1, 1'b0, 12'h001, '0);
    #1 chk("rst_rd_gnt", 64'(bus.dbg_gnt), 64'(1));
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_stall",  64'(bus.cpu_stall),  64'(0));
    chk("rst_async_gnt",    64'(bus.dbg_gnt),    64'(0));
    chk("rst_async_rvalid", 64'(bus.dbg_rvalid), 64'(0));
    chk("rst_async_dbg_q",  64'(bus.dbg_q),      64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 chk("rst_no_rvalid", 64'(bus.dbg_rvalid), 64'(0));
      @(negedge clk);
    end
    $display("[TB] reset during read: no stale rvalid");

    // ---------------- randomized run against the reference model ----------------
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < READ_LAT; i++) rq[i] = '0;
    denied   = 0;
    last_gnt = 1'b1;
    load     = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 100 == 0) load = $urandom_range(0, 3);
      drive_cpu(($urandom_range(0, 7) < ((load == 0) ? 2 : (load == 1) ? 5 : 8)),
                1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
      if (!bus.dbg_req || last_gnt)
        drive_dbg(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                  12'($urandom_range(0, 15)), $urandom);

      // A forced slot comes after STARVE_LIMIT consecutive denied cycles.
      force_e = (denied == STARVE_LIMIT);
      gnt_e   = force_e || (bus.dbg_req && !bus.cpu_en);
      wren_e  = gnt_e ? bus.dbg_wren : (bus.cpu_en && bus.cpu_wren);
      addr_e  = gnt_e ? bus.dbg_addr : bus.cpu_addr;
      data_e  = gnt_e ? bus.dbg_d    : bus.cpu_d;
      exp_rv  = (rvq.size() > 0) && (rvq[0].due == cyc);

      #1;
      chk("rnd_gnt",    64'(bus.dbg_gnt),      64'(gnt_e));
      chk("rnd_stall",  64'(bus.cpu_stall),    64'(force_e));
      chk("rnd_wren",   64'(bus.wren),         64'(wren_e));
      chk("rnd_addr",   64'(bus.address_dmem), 64'(addr_e));
      chk("rnd_data",   64'(bus.data),         64'(data_e));
      chk("rnd_rvalid", 64'(bus.dbg_rvalid),   64'(exp_rv));
      if (exp_rv) begin
        chk("rnd_dbg_q", 64'(bus.dbg_q), 64'(rvq[0].d));
        void'(rvq.pop_front());
      end
      if (cyc >= READ_LAT) chk("rnd_cpu_q", 64'(bus.cpu_q), 64'(rq[READ_LAT-1]));
      if (gnt_e)
        $display("[TB] rnd cyc %0d dbg %s addr=0x%03h forced=%0b", cyc,
                 bus.dbg_wren ? "wr" : "rd", bus.dbg_addr, force_e);

      for (int i = READ_LAT - 1; i > 0; i--) rq[i] = rq[i-1];
      rq[0] = ref_mem[addr_e];
      if (gnt_e && !bus.dbg_wren) rvq.push_back('{cyc + READ_LAT + 1, ref_mem[addr_e]});
      if (wren_e) ref_mem[addr_e] = data_e;
      denied   = (gnt_e || !bus.dbg_req) ? 0 : denied + 1;
      last_gnt = gnt_e;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
